axi_lite_arbiter: RTL and testbench

- Parametrised N-master to 1-slave AXI-lite arbiter.
- Lets the fetch unit, lsu and future masters (e.g. debug, DMA) share one memory port. Today the single fetch master connects point-to-point to isram.
- Round-robin fairness; exactly one outstanding transaction, read or write, at a time.
- Sits between the core's AXI-lite masters and the memory/bus slave.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/rr_picker.sv | 38 +++
 rtl/axi_lite_arbiter.sv | 166 ++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// ==== axi_pkg -- AXI-lite response codes, arbiter state encoding, default widths ====
// ==== Rev 1.0 ====
`default_nettype none

package axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ==== rr_picker -- rotating-priority picker: first requester at or above ptr, wrapping ====
// ==== Rev 1.0 ====
`default_nettype none

module rr_picker #(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [N_MASTERS-1:0] onehot,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] c;
    cand   = 0;
    c      = '0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int off = 0; off < N_MASTERS; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      c = IDX_W'(cand);
      if (!any && req[c]) begin
        any       = 1'b1;
        idx       = c;
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_lite_arbiter.sv
// ==== axi_lite_arbiter -- N:1 round-robin AXI-lite arbiter, one outstanding transaction ====
// ==== Rev 1.0 ====
`default_nettype none

module axi_lite_arbiter
  import axi_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = AXI_ADDR_W,
  parameter int DATA_W    = AXI_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
  input  logic [N_MASTERS-1:0]          m_arvalid,
  output logic [N_MASTERS-1:0]          m_arready,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
  output logic [N_MASTERS*2-1:0]        m_rresp,
  output logic [N_MASTERS-1:0]          m_rvalid,
  input  logic [N_MASTERS-1:0]          m_rready,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
  input  logic [N_MASTERS-1:0]          m_awvalid,
  output logic [N_MASTERS-1:0]          m_awready,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  input  logic [N_MASTERS-1:0]          m_wvalid,
  output logic [N_MASTERS-1:0]          m_wready,
  output logic [N_MASTERS*2-1:0]        m_bresp,
  output logic [N_MASTERS-1:0]          m_bvalid,
  input  logic [N_MASTERS-1:0]          m_bready,
  output logic [ADDR_W-1:0]             s_araddr,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  output logic [ADDR_W-1:0]             s_awaddr,
  output logic                          s_awvalid,
  input  logic                          s_awready,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wstrb,
  output logic                          s_wvalid,
  input  logic                          s_wready,
  input  logic [1:0]                    s_bresp,
  input  logic                          s_bvalid,
  output logic                          s_bready
);

  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;

  arb_state_e           r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_gnt, w_gnt_nxt, r_rr_ptr, w_rr_ptr_nxt, w_gnt_inc, w_pick_idx;
  logic                 r_ar_done, r_aw_done, r_w_done;
  logic                 w_ar_done_nxt, w_aw_done_nxt, w_w_done_nxt;
  logic [N_MASTERS-1:0] w_req, w_pick_oh;
  logic                 w_pick_any;

  logic [ADDR_W-1:0] w_araddr [N_MASTERS];
  logic [ADDR_W-1:0] w_awaddr [N_MASTERS];
  logic [DATA_W-1:0] w_wdata  [N_MASTERS];
  logic [STRB_W-1:0] w_wstrb  [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign w_araddr[i] = m_araddr[i*ADDR_W +: ADDR_W];
    assign w_awaddr[i] = m_awaddr[i*ADDR_W +: ADDR_W];
    assign w_wdata[i]  = m_wdata[i*DATA_W +: DATA_W];
    assign w_wstrb[i]  = m_wstrb[i*STRB_W +: STRB_W];
  end

  assign w_req     = m_arvalid | m_awvalid;
  assign w_gnt_inc = (r_gnt == IDX_W'(N_MASTERS - 1)) ? '0 : r_gnt + IDX_W'(1);

  rr_picker #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_rr_picker (
    .req    (w_req),
    .ptr    (r_rr_ptr),
    .onehot (w_pick_oh),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_ar_done_nxt = r_ar_done;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    m_arready = '0;  m_rdata  = '0;  m_rresp  = '0;  m_rvalid = '0;
    m_awready = '0;  m_wready = '0;  m_bresp  = '0;  m_bvalid = '0;
    s_araddr  = '0;  s_arvalid = 1'b0;  s_rready = 1'b0;
    s_awaddr  = '0;  s_awvalid = 1'b0;
    s_wdata   = '0;  s_wstrb   = '0;    s_wvalid = 1'b0;  s_bready = 1'b0;
    case (r_state)
      IDLE: begin
        // Read wins when the picked master offers both AR and AW.
        if (w_pick_any) begin
          w_gnt_nxt   = w_pick_idx;
          w_state_nxt = (|(w_pick_oh & m_arvalid)) ? RD : WR;
        end
      end
      RD: begin
        s_araddr           = w_araddr[r_gnt];
        s_arvalid          = m_arvalid[r_gnt] & ~r_ar_done;
        m_arready[r_gnt]   = s_arready & ~r_ar_done;
        s_rready           = m_rready[r_gnt];
        m_rvalid[r_gnt]    = s_rvalid;
        m_rdata            = {N_MASTERS{s_rdata}};
        m_rresp            = {N_MASTERS{s_rresp}};
        if (s_arvalid && s_arready) w_ar_done_nxt = 1'b1;
        if (s_rvalid && s_rready) begin
          w_state_nxt   = IDLE;
          w_ar_done_nxt = 1'b0;
          w_rr_ptr_nxt  = w_gnt_inc;
        end
      end
      WR: begin
        s_awaddr           = w_awaddr[r_gnt];
        s_awvalid          = m_awvalid[r_gnt] & ~r_aw_done;
        m_awready[r_gnt]   = s_awready & ~r_aw_done;
        s_wdata            = w_wdata[r_gnt];
        s_wstrb            = w_wstrb[r_gnt];
        s_wvalid           = m_wvalid[r_gnt] & ~r_w_done;
        m_wready[r_gnt]    = s_wready & ~r_w_done;
        s_bready           = m_bready[r_gnt];
        m_bvalid[r_gnt]    = s_bvalid;
        m_bresp            = {N_MASTERS{s_bresp}};
        if (s_awvalid && s_awready) w_aw_done_nxt = 1'b1;
        if (s_wvalid && s_wready)   w_w_done_nxt  = 1'b1;
        // An early B (before AW and W both completed) still closes the transaction.
        if (s_bvalid && s_bready) begin
          w_state_nxt   = IDLE;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_rr_ptr_nxt  = w_gnt_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_rr_ptr  <= '0;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_ar_done <= w_ar_done_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
// ==== tb_axi_lite_arbiter -- directed self-checking bench for axi_lite_arbiter ====
// ==== Rev 1.0 ====
`default_nettype none

module tb_axi_lite_arbiter;
  import axi_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;

  logic [N*AW-1:0] m_araddr, m_awaddr;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N*DW-1:0] m_rdata, m_wdata;
  logic [N*2-1:0]  m_rresp, m_bresp;
  logic [N*SW-1:0] m_wstrb;

  logic [AW-1:0] s_araddr, s_awaddr;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [1:0]    s_rresp, s_bresp;
  logic [SW-1:0] s_wstrb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_lite_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hs"}, 64'({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
                             m_arready, m_rvalid, m_awready, m_wready, m_bvalid}), 64'd0);
    check({tag, "_addr"}, {s_araddr, s_awaddr}, 64'd0);
    check({tag, "_data"}, 64'({s_wdata, s_wstrb, m_rresp, m_bresp}), 64'd0);
  endtask

  // Grant arrives on the next edge; AR handshake, one R beat, then back to IDLE.
  task automatic serve_read(input int m, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input string tag);
    logic [N-1:0] oh;
    oh = N'(1) << m;
    cyc();
    check({tag, "_arvalid"}, 64'(s_arvalid), 64'd1);
    check({tag, "_araddr"},  64'(s_araddr), 64'(addr));
    check({tag, "_arready"}, 64'(m_arready), 64'(oh));
    check({tag, "_no_wr"},   64'({s_awvalid, s_wvalid}), 64'd0);
    cyc();
    m_arvalid = m_arvalid & ~oh;
    s_rvalid  = 1'b1;
    s_rdata   = data;
    s_rresp   = RESP_EXOKAY;
    #1;
    check({tag, "_ar_low"}, 64'(s_arvalid), 64'd0);
    check({tag, "_rvalid"}, 64'(m_rvalid), 64'(oh));
    check({tag, "_rdata"},  64'(DW'(m_rdata >> (m * DW))), 64'(data));
    check({tag, "_rready"}, 64'(s_rready), 64'd1);
    cyc();
    s_rvalid = 1'b0;
    s_rdata  = '0;
    s_rresp  = '0;
    #1;
    check({tag, "_idle"}, 64'({m_rvalid, s_rready}), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
    m_rready = '1; m_bready = '1;
    s_arready = 1'b1; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    check_idle("reset");

    // Single read by master 1
    m_araddr  = {32'h8000_0010, 32'h0};
    m_arvalid = 2'b10;
    #1;
    check("t1_pre_arvalid", 64'(s_arvalid), 64'd0);
    serve_read(1, 32'h8000_0010, 32'hDEAD_BEEF, "t1");

    // Simultaneous pair from rr_ptr=0: m0 then m1
    m_araddr  = {32'h0000_2000, 32'h0000_1000};
    m_arvalid = 2'b11;
    serve_read(0, 32'h0000_1000, 32'hA0A0_0001, "t2a");
    serve_read(1, 32'h0000_2000, 32'hB0B0_0002, "t2b");
    // Lone m0 read moves rr_ptr to 1, so the next pair goes m1 then m0
    m_araddr  = {32'h0000_2004, 32'h0000_1004};
    m_arvalid = 2'b01;
    serve_read(0, 32'h0000_1004, 32'hA0A0_0003, "t2c");
    m_arvalid = 2'b11;
    serve_read(1, 32'h0000_2004, 32'hB0B0_0004, "t2d");
    serve_read(0, 32'h0000_1004, 32'hA0A0_0005, "t2e");

    // Split-handshake write by m1: AW on cycle 1, W on cycle 3, B on cycle 5
    m_awaddr  = {32'h8000_0100, 32'h0};
    m_wdata   = {32'h1234_5678, 32'h0};
    m_wstrb   = {4'hF, 4'h0};
    m_awvalid = 2'b10;
    m_wvalid  = 2'b10;
    #1;
    check("t3_pre_awvalid", 64'(s_awvalid), 64'd0);
    cyc();
    s_awready = 1'b1;
    #1;
    check("t3_c1_awvalid", 64'(s_awvalid), 64'd1);
    check("t3_c1_awaddr",  64'(s_awaddr), 64'h8000_0100);
    check("t3_c1_w",       64'({s_wvalid, s_wstrb, s_wdata}), 64'h1_F_1234_5678);
    check("t3_c1_readies", 64'({m_awready, m_wready}), 64'b10_00);
    cyc();
    #1;
    check("t3_c2_aw_mask", 64'({s_awvalid, m_awready}), 64'd0);
    check("t3_c2_wvalid",  64'(s_wvalid), 64'd1);
    cyc();
    m_awvalid = 2'b00;
    s_awready = 1'b0;
    s_wready  = 1'b1;
    #1;
    check("t3_c3_wready", 64'({s_wvalid, m_wready, m_bvalid}), 64'b1_10_00);
    cyc();
    m_wvalid = 2'b00;
    s_wready = 1'b0;
    #1;
    check("t3_c4_quiet", 64'({s_wvalid, m_bvalid}), 64'd0);
    cyc();
    s_bvalid = 1'b1;
    s_bresp  = RESP_SLVERR;
    #1;
    check("t3_c5_bvalid", 64'({m_bvalid, s_bready}), 64'b10_1);
    check("t3_c5_bresp",  64'(m_bresp[3:2]), 64'(RESP_SLVERR));
    cyc();
    s_bvalid = 1'b0;
    s_bresp  = '0;
    #1;
    check("t3_c6_idle", 64'({m_bvalid, s_bready}), 64'd0);

    // m0 presents AR and AW together: read first, write on the following grant
    m_araddr  = {32'h0, 32'h0000_3000};
    m_awaddr  = {32'h0, 32'h0000_3004};
    m_wdata   = {32'h0, 32'hCAFE_F00D};
    m_wstrb   = {4'h0, 4'h3};
    m_arvalid = 2'b01;
    m_awvalid = 2'b01;
    m_wvalid  = 2'b01;
    serve_read(0, 32'h0000_3000, 32'h55AA_55AA, "t4rd");
    cyc();
    s_awready = 1'b1;
    s_wready  = 1'b1;
    #1;
    check("t4_wr_grant", 64'({s_arvalid, s_awvalid, s_wvalid, m_awready, m_wready}), 64'b0_1_1_01_01);
    check("t4_wr_fields", {s_awaddr, s_wstrb, 28'h0}, {32'h0000_3004, 4'h3, 28'h0});
    cyc();
    m_awvalid = 2'b00;
    m_wvalid  = 2'b00;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b1;
    #1;
    check("t4_bvalid", 64'(m_bvalid), 64'b01);
    cyc();
    s_bvalid = 1'b0;
    #1;
    check("t4_idle", 64'(m_bvalid), 64'd0);

    // Backpressure: m0 holds rready low for 4 cycles while R is valid
    m_araddr  = {32'h0, 32'h0000_4000};
    m_arvalid = 2'b01;
    m_rready  = 2'b10;
    cyc();
    check("t5_arvalid", 64'(s_arvalid), 64'd1);
    cyc();
    m_arvalid = 2'b00;
    s_rvalid  = 1'b1;
    s_rdata   = 32'h0BAD_CAFE;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t5_hold_rready", 64'(s_rready), 64'd0);
      check("t5_hold_rvalid", 64'(m_rvalid), 64'b01);
      cyc();
    end
    m_rready = 2'b11;
    #1;
    check("t5_release", 64'({s_rready, m_rvalid, m_rdata[31:0]}), {29'h0, 1'b1, 2'b01, 32'h0BAD_CAFE});
    cyc();
    s_rvalid = 1'b0;
    s_rdata  = '0;
    #1;
    check("t5_done", 64'({m_rvalid, s_rready}), 64'd0);

    // Reset in WR after AW handshake, before W
    m_awaddr  = {32'h8000_0200, 32'h0};
    m_wdata   = {32'h7777_0000, 32'h0};
    m_awvalid = 2'b10;
    m_wvalid  = 2'b10;
    s_awready = 1'b1;
    s_wready  = 1'b0;
    cyc();
    check("t6_awready", 64'(m_awready), 64'b10);
    cyc();
    m_awvalid = 2'b00;
    rst       = 1'b1;
    #1;
    check("t6_mid_write", 64'({s_awvalid, s_wvalid}), 64'b01);
    cyc();
    rst       = 1'b0;
    m_wvalid  = 2'b00;
    s_awready = 1'b0;
    #1;
    check_idle("t6_rst");
    // rr_ptr was 1 before reset; a pair now must start at m0
    m_araddr  = {32'h8000_0300, 32'h0000_5000};
    m_arvalid = 2'b11;
    serve_read(0, 32'h0000_5000, 32'h1111_2222, "t6a");
    serve_read(1, 32'h8000_0300, 32'h3333_4444, "t6b");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
